// File: rtl/riscv_unified_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// riscv_unified_mem_arbiter_pkg
// Shared types for the unified memory arbiter: the transaction FSM states,
// the owner encoding (which pipeline port a memory transaction belongs to),
// the width of the fetch starvation counter, and the arbitration rule.
// ---------------------------------------------------------------------------
package riscv_unified_mem_arbiter_pkg;

    // Transaction sequencing: pick a winner, hold the request, wait for data
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Which pipeline port owns the transaction currently on the memory side
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Wide enough for the largest permitted starvation limit (15)
    localparam int STARVE_CNT_W = 4;

    // Data port wins by default; fetch wins when it is alone or has been
    // starved for the configured number of consecutive losses.
    function automatic owner_t pick_owner(input logic if_req,
                                          input logic d_req,
                                          input logic if_starved);
        if (if_req && (!d_req || if_starved)) begin
            return OWN_IF;
        end
        return OWN_D;
    endfunction

endpackage

// File: rtl/riscv_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_unified_mem_arbiter
// Shares one single-ported unified memory between the IF stage (read-only
// fetch) and the MEM stage (loads and stores). Only one transaction is in
// flight at a time. Data requests take priority; a starvation counter forces
// a fetch grant after STARVE_MAX consecutive fetch losses. A branch flush
// while a fetch is in flight marks the fetch stale so that its response is
// swallowed instead of being delivered to the pipeline.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush       fetch request, PC, stale-fetch indication
//   if_valid/if_rdata/if_stall    fetch response pulse, instruction, stall
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data request and store fields
//   d_valid/d_rdata/d_stall       load data / store ack pulse, data, stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   latched memory request
//   mem_gnt/mem_rvalid/mem_rdata  memory handshake and response
// ---------------------------------------------------------------------------
module riscv_unified_mem_arbiter
    import riscv_unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    arb_state_t              state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic                    kill_q, kill_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    resp_seen;

    // State and latched transaction fields. Reset abandons any transaction in
    // flight; a late memory response then arrives in IDLE and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            kill_q   <= 1'b0;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            kill_q   <= kill_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    // Next-state logic. Arbitration happens only in IDLE, so the winner's
    // fields are captured once and held steady for the whole REQ/WAIT span.
    // The stale-fetch flag is only meaningful while a fetch is in flight; in
    // IDLE the pipeline simply presents the redirected PC as a new request.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        kill_d   = kill_q;
        starve_d = starve_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (if_req || d_req) begin
                    owner_d = pick_owner(if_req, d_req, starve_q == STARVE_LIM);
                    state_d = ST_REQ;
                    if (owner_d == OWN_IF) begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        starve_d = '0;
                    end else begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_we ? d_wdata : '0;
                        wstrb_d = d_we ? d_wstrb : 4'h0;
                        if (if_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (if_flush && (owner_q == OWN_IF)) begin
                    kill_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (if_flush && (owner_q == OWN_IF)) begin
                    kill_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side request is a pure decode of the registered state, so it
    // rises one cycle after the winning request was seen.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    // Response pulses come straight from mem_rvalid; a flush in the same
    // cycle as the fetch data still suppresses it.
    assign resp_seen = (state_q == ST_WAIT) && mem_rvalid;
    assign if_valid  = resp_seen && (owner_q == OWN_IF) && !kill_q && !if_flush;
    assign d_valid   = resp_seen && (owner_q == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    assign if_stall  = if_req && !if_valid;
    assign d_stall   = d_req && !d_valid;

endmodule

// File: tb/tb_riscv_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_unified_mem_arbiter
// Plays both pipeline ports and the memory. A transaction-level model decides
// which port should be served next and what it should return; expectations
// go into queues that a memory responder and an output monitor pop.
// ---------------------------------------------------------------------------
module tb_riscv_unified_mem_arbiter;

    localparam int STARVE  = 4;
    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct packed {
        logic        is_store;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid, if_stall;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_valid, d_stall;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem  [256];
    logic [31:0] phys_mem [256];
    txn_t  mem_exp_q[$];
    resp_t if_exp_q[$];
    resp_t d_exp_q[$];
    txn_t  grant_log[$];

    // Memory responder knobs and status
    int   gnt_pct = 100;
    int   max_delay = 0;
    int   spur_pct = 0;
    bit   resp_hold = 1'b0;
    bit   resp_enable = 1'b1;
    bit   r_busy = 1'b0;
    bit   resp_real = 1'b0;
    int   r_delay = 0;
    logic [31:0] r_data = '0;

    riscv_unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event occurred, expected none", name);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return {22'b0, 8'($urandom_range(255)), 2'b00};
    endfunction

    // Reference model: one transaction at a time, decided when the memory is
    // free; data wins unless fetch has already lost STARVE times in a row.
    logic m_busy = 1'b0, m_own_if = 1'b0, m_killed = 1'b0;
    int   m_losses = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_killed = 1'b0; m_losses = 0;
            if_exp_q.delete(); d_exp_q.delete(); mem_exp_q.delete();
        end else if (m_busy) begin
            if (m_own_if && if_flush && !m_killed) begin
                m_killed = 1'b1;
                if (if_exp_q.size() > 0) void'(if_exp_q.pop_back());
            end
            if (resp_real) m_busy = 1'b0;
        end else if (if_req || d_req) begin
            txn_t  t;
            resp_t r;
            m_busy = 1'b1;
            m_killed = 1'b0;
            if (if_req && (!d_req || m_losses >= STARVE)) begin
                m_own_if = 1'b1;
                m_losses = 0;
                t = '{we: 1'b0, addr: if_addr, wdata: 32'h0, wstrb: 4'h0};
                r = '{is_store: 1'b0, data: ref_mem[if_addr[9:2]]};
                if_exp_q.push_back(r);
            end else begin
                m_own_if = 1'b0;
                if (if_req) m_losses++;
                t = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
                if (d_we) begin
                    ref_mem[d_addr[9:2]] = merge(ref_mem[d_addr[9:2]], d_wdata, d_wstrb);
                    r = '{is_store: 1'b1, data: 32'h0};
                end else begin
                    r = '{is_store: 1'b0, data: ref_mem[d_addr[9:2]]};
                end
                d_exp_q.push_back(r);
            end
            mem_exp_q.push_back(t);
        end
    end

    // Memory responder: grants with a configurable probability, answers after
    // a random delay, and can inject responses that no request asked for.
    initial forever begin
        @(posedge clk);
        #1;
        if (!resp_enable) continue;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        resp_real = 1'b0;
        mem_rdata = $urandom;
        if (!rst_n) begin
            r_busy = 1'b0;
        end else if (r_busy) begin
            if (!resp_hold) begin
                if (r_delay == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = r_data;
                    resp_real = 1'b1;
                    r_busy = 1'b0;
                end else begin
                    r_delay--;
                end
            end
        end else if (mem_req && ($urandom_range(99) < gnt_pct)) begin
            txn_t g;
            mem_gnt = 1'b1;
            g = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
            grant_log.push_back(g);
            if (mem_exp_q.size() == 0) begin
                flag_fail("mem_grant_unexpected");
            end else begin
                txn_t e;
                e = mem_exp_q.pop_front();
                check_output("mem_we", 32'(mem_we), 32'(e.we));
                check_output("mem_addr", mem_addr, e.addr);
                if (e.we) begin
                    check_output("mem_wdata", mem_wdata, e.wdata);
                    check_output("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                end
            end
            if (mem_we) phys_mem[mem_addr[9:2]] = merge(phys_mem[mem_addr[9:2]], mem_wdata, mem_wstrb);
            r_data = phys_mem[mem_addr[9:2]];
            r_busy = 1'b1;
            r_delay = $urandom_range(max_delay);
        end else if ($urandom_range(99) < spur_pct) begin
            mem_rvalid = 1'b1;
        end
    end

    // Output monitor: every response pulse must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (!rst_n) continue;
        if (if_valid) begin
            if (if_exp_q.size() == 0) begin
                flag_fail("if_valid_unexpected");
            end else begin
                resp_t r;
                r = if_exp_q.pop_front();
                check_output("if_rdata", if_rdata, r.data);
            end
        end
        if (d_valid) begin
            if (d_exp_q.size() == 0) begin
                flag_fail("d_valid_unexpected");
            end else begin
                resp_t r;
                r = d_exp_q.pop_front();
                if (!r.is_store) check_output("d_rdata", d_rdata, r.data);
            end
        end
    end

    task automatic d_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        bit done;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        done = 1'b0;
        for (int n = 0; n < TIMEOUT && !done; n++) begin
            @(negedge clk);
            if (d_valid) begin
                check_output("d_stall_on_valid", 32'(d_stall), 32'h0);
                done = 1'b1;
            end else begin
                check_output("d_stall_waiting", 32'(d_stall), 32'h1);
            end
        end
        if (!done) flag_fail("d_timeout");
    endtask

    task automatic d_idle();
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic if_fetch(input logic [31:0] pc, input int flush_pct);
        bit done;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = pc; if_flush = 1'b0;
        done = 1'b0;
        for (int n = 0; n < TIMEOUT && !done; n++) begin
            @(negedge clk);
            if (if_valid) begin
                check_output("if_stall_on_valid", 32'(if_stall), 32'h0);
                done = 1'b1;
            end else begin
                check_output("if_stall_waiting", 32'(if_stall), 32'h1);
                @(posedge clk); #1;
                if_flush = 1'b0;
                if ($urandom_range(99) < flush_pct) begin
                    if_flush = 1'b1;
                    if_addr = rand_addr();
                end
            end
        end
        if (!done) flag_fail("if_timeout");
    endtask

    task automatic if_idle();
        @(posedge clk); #1;
        if_req = 1'b0; if_flush = 1'b0;
    endtask

    task automatic check_grant(input string name, input int idx, input logic we, input logic [31:0] addr);
        if (idx >= grant_log.size()) begin
            flag_fail({name, "_missing"});
        end else begin
            check_output({name, "_we"}, 32'(grant_log[idx].we), 32'(we));
            check_output({name, "_addr"}, grant_log[idx].addr, addr);
        end
    endtask

    task automatic wait_granted(input string name);
        for (int n = 0; n < 50 && !r_busy; n++) @(negedge clk);
        if (!r_busy) flag_fail(name);
    endtask

    // Two independent random requesters running against each other.
    task automatic apply_stimulus(input int n_if, input int n_d, input int flush_pct);
        fork
            begin
                for (int i = 0; i < n_if; i++) begin
                    if_fetch(rand_addr(), flush_pct);
                    if ($urandom_range(1) == 1) if_idle();
                end
                if_idle();
            end
            begin
                for (int i = 0; i < n_d; i++) begin
                    d_access(1'($urandom_range(1)), rand_addr(), $urandom, 4'($urandom_range(15)));
                    if ($urandom_range(1) == 1) d_idle();
                end
                d_idle();
            end
        join
    endtask

    initial begin
        #1_000_000;
        flag_fail("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit seen;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = init_word(i);
            phys_mem[i] = init_word(i);
        end

        // Reset state
        #22;
        check_output("rst_mem_req", 32'(mem_req), 32'h0);
        check_output("rst_if_valid", 32'(if_valid), 32'h0);
        check_output("rst_d_valid", 32'(d_valid), 32'h0);
        check_output("rst_mem_we", 32'(mem_we), 32'h0);
        check_output("rst_mem_addr", mem_addr, 32'h0);
        check_output("rst_mem_wdata", mem_wdata, 32'h0);
        check_output("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        rst_n = 1'b1;

        // Single fetch at 0x0: mem_req one cycle later, response two after that
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clk);
        check_output("t1_mem_req_n", 32'(mem_req), 32'h0);
        check_output("t1_if_stall_n", 32'(if_stall), 32'h1);
        @(negedge clk);
        check_output("t1_mem_req_n1", 32'(mem_req), 32'h1);
        check_output("t1_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        check_output("t1_if_valid", 32'(if_valid), 32'h1);
        check_output("t1_if_stall_valid", 32'(if_stall), 32'h0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check_output("t1_if_valid_after", 32'(if_valid), 32'h0);
        check_output("t1_if_stall_after", 32'(if_stall), 32'h0);

        // Simultaneous fetch and load: data first, fetch next
        base = grant_log.size();
        fork
            begin if_fetch(32'h40, 0); if_idle(); end
            begin d_access(1'b0, 32'd200, 32'h0, 4'h0); d_idle(); end
        join
        check_grant("t2_first", base, 1'b0, 32'd200);
        check_grant("t2_second", base + 1, 1'b0, 32'h40);

        // Starvation guard: fifth grant goes to the waiting fetch
        base = grant_log.size();
        fork
            begin if_fetch(32'h300, 0); if_idle(); end
            begin
                for (int i = 0; i < 6; i++) d_access(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
                d_idle();
            end
        join
        check_grant("t3_grant4", base + 3, 1'b0, 32'h10c);
        check_grant("t3_grant5", base + 4, 1'b0, 32'h300);
        check_grant("t3_grant6", base + 5, 1'b0, 32'h110);

        // Flush while fetch waits for memory: stale word never delivered
        resp_hold = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h80;
        wait_granted("t4_grant_timeout");
        @(posedge clk); #1;
        if_flush = 1'b1; if_addr = 32'h104;
        @(negedge clk);
        check_output("t4_if_valid_flush", 32'(if_valid), 32'h0);
        @(posedge clk); #1;
        if_flush = 1'b0;
        @(negedge clk);
        resp_hold = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (if_valid) begin
                check_output("t4_new_word", if_rdata, init_word(65));
                seen = 1'b1;
            end
        end
        if (!seen) flag_fail("t4_if_timeout");
        if_idle();

        // Store with full strobes, then read it back
        base = grant_log.size();
        d_access(1'b1, 32'd228, 32'h0001_0078, 4'hF);
        d_idle();
        check_grant("t5_store", base, 1'b1, 32'd228);
        if (base < grant_log.size()) begin
            check_output("t5_wdata", grant_log[base].wdata, 32'h0001_0078);
            check_output("t5_wstrb", 32'(grant_log[base].wstrb), 32'hF);
        end
        @(negedge clk);
        check_output("t5_d_stall_after", 32'(d_stall), 32'h0);
        d_access(1'b0, 32'd228, 32'h0, 4'h0);
        d_idle();

        // Reset during WAIT: everything drops and a late response is ignored
        resp_hold = 1'b1;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        wait_granted("t6_grant_timeout");
        @(posedge clk); #1;
        d_req = 1'b0;
        #2;
        resp_enable = 1'b0;
        rst_n = 1'b0;
        r_busy = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        resp_real = 1'b0;
        #1;
        check_output("t6_mem_req", 32'(mem_req), 32'h0);
        check_output("t6_mem_addr", mem_addr, 32'h0);
        check_output("t6_d_valid", 32'(d_valid), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        resp_hold = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_output("t6_late_d_valid", 32'(d_valid), 32'h0);
        check_output("t6_late_if_valid", 32'(if_valid), 32'h0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        resp_enable = 1'b1;

        // Random traffic: slow memory with spurious responses, then fast memory
        gnt_pct = 70; max_delay = 2; spur_pct = 10;
        apply_stimulus(40, 40, 10);
        gnt_pct = 100; max_delay = 0; spur_pct = 0;
        apply_stimulus(30, 30, 0);

        repeat (10) @(negedge clk);
        check_output("left_if_exp", 32'(if_exp_q.size()), 32'h0);
        check_output("left_d_exp", 32'(d_exp_q.size()), 32'h0);
        check_output("left_mem_exp", 32'(mem_exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
